pdp8_trace_buffer: RTL and testbench

//  Synthesizable instruction-trace unit beside the pdp8 core. Records one entry per instruction

---
 rtl/pdp8_trace_buffer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pdp8_trace_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_trace_buffer.sv
// -----------------------------------------------------------------------------
// pdp8_trace_buffer
//
// Instruction-trace unit that sits beside the pdp8 core. It records one entry
// per instruction fetch ({pc, mb, l, ac, ion}) into a circular buffer of
// 2**DEPTH_LOG2 entries. The buffer is read out FIFO-style by the front panel
// or a host. Capture can wait for a PC trigger, and it freezes when the core
// halts.
//
// Optional feature macro: PDP8_TRACE_LIMIT_EN
//   When defined, the module gains a `limit` input and a `stop_req` output.
//   Capture freezes, and stop_req is raised, once `fetches` reaches a
//   non-zero limit.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous reset, active low
//   state      in   core state (4 bits)
//   pc         in   core program counter (ADDR_W bits)
//   mb         in   core memory buffer, the instruction word at fetch (12 bits)
//   ac         in   core accumulator (12 bits)
//   l          in   core link
//   ion        in   core interrupt enable
//   arm        in   one-cycle pulse: clear the buffer and start a new session
//   trig_en    in   1 = wait for pc == trig_pc before capturing
//   trig_pc    in   trigger address (ADDR_W bits)
//   limit      in   fetch limit, 0 = none (only with PDP8_TRACE_LIMIT_EN)
//   rd_ready   in   consumer takes rd_data this cycle
//   rd_valid   out  buffer is non-empty
//   rd_data    out  oldest entry {pc, mb, l, ac, ion} (ADDR_W+26 bits)
//   count      out  number of entries held (DEPTH_LOG2+1 bits)
//   fetches    out  fetches seen since arm; saturates (CNT_W bits)
//   capturing  out  FSM is in CAPTURE
//   halted     out  sticky: halt was seen while capturing
//   overflow   out  sticky: an entry was lost or overwritten
//   stop_req   out  fetch limit reached (only with PDP8_TRACE_LIMIT_EN)
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_OFF    | idle after reset; no writes; readout still works
//   S_WAIT   | armed with trigger; waiting for a fetch at trig_pc
//   S_CAPTURE| recording one entry per fetch event
//   S_FROZEN | halt, full (no-wrap) or limit reached; no writes; readout works
// -----------------------------------------------------------------------------
module pdp8_trace_buffer #(
    parameter int           ADDR_W      = 15,
    parameter int           DEPTH_LOG2  = 6,
    parameter int           CNT_W       = 32,
    parameter logic [3:0]   FETCH_STATE = 4'b0000,
    parameter logic [3:0]   HALT_STATE  = 4'b1100,
    parameter bit           WRAP_MODE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              state,
    input  logic [ADDR_W-1:0]       pc,
    input  logic [11:0]             mb,
    input  logic [11:0]             ac,
    input  logic                    l,
    input  logic                    ion,
    input  logic                    arm,
    input  logic                    trig_en,
    input  logic [ADDR_W-1:0]       trig_pc,
`ifdef PDP8_TRACE_LIMIT_EN
    input  logic [CNT_W-1:0]        limit,
    output logic                    stop_req,
`endif
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [ADDR_W+25:0]      rd_data,
    output logic [DEPTH_LOG2:0]     count,
    output logic [CNT_W-1:0]        fetches,
    output logic                    capturing,
    output logic                    halted,
    output logic                    overflow
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  ENTRY_W  = ADDR_W + 26;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_FROZEN  = 2'd3
    } fsm_t;

    fsm_t                   fsm_q;
    fsm_t                   fsm_nxt;

    logic [3:0]             state_d;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    cnt_q;
    logic [CNT_W-1:0]       fetch_cnt;
    logic                   halted_q;
    logic                   overflow_q;

    logic                   fetch_ev;
    logic                   trig_hit;
    logic                   accept;
    logic                   not_empty;
    logic                   full;
    logic                   pop;
    logic                   drop;
    logic                   write;
    logic                   overwrite;
    logic                   fetch_sat;
    logic                   limit_hit;
    logic [ENTRY_W-1:0]     entry;

    // A fetch event fires only on the first cycle of FETCH, however long the
    // core stays in that state.
    assign fetch_ev  = (state == FETCH_STATE) && (state_d != FETCH_STATE);
    assign trig_hit  = fetch_ev && (pc == trig_pc);

    // arm wins over a coincident fetch: that event is not recorded.
    assign accept    = !arm && (((fsm_q == S_CAPTURE) && fetch_ev) ||
                                ((fsm_q == S_WAIT) && trig_hit));

    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == FULL_CNT);
    assign pop       = not_empty && rd_ready && !arm;

    // A pop in the same cycle frees the slot, so a push into a full buffer
    // only overflows when nothing is being read out.
    assign drop      = accept && full && !pop && !WRAP_MODE;
    assign write     = accept && !drop;
    assign overwrite = write && full && !pop;
    assign fetch_sat = &fetch_cnt;
    assign entry     = {pc, mb, l, ac, ion};

`ifdef PDP8_TRACE_LIMIT_EN
    logic stop_q;

    // The limit is hit on the edge where the counter reaches the limit, so
    // the fetch that makes the count equal to limit is still recorded.
    assign limit_hit = accept && (limit != '0) && !fetch_sat &&
                       ((fetch_cnt + CNT_W'(1)) == limit);
    assign stop_req  = stop_q;
`else
    assign limit_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q <= S_OFF;
        end else begin
            fsm_q <= fsm_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        fsm_nxt = fsm_q;
        if (arm) begin
            fsm_nxt = trig_en ? S_WAIT : S_CAPTURE;
        end else begin
            case (fsm_q)
                S_WAIT: begin
                    if (trig_hit) begin
                        fsm_nxt = limit_hit ? S_FROZEN : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if ((state == HALT_STATE) || drop || limit_hit) begin
                        fsm_nxt = S_FROZEN;
                    end
                end
                default: fsm_nxt = fsm_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM / readout outputs
    // -------------------------------------------------------------------------
    always_comb begin
        capturing = (fsm_q == S_CAPTURE);
        rd_valid  = not_empty;
        rd_data   = not_empty ? mem[rd_ptr] : '0;
        count     = cnt_q;
        fetches   = fetch_cnt;
        halted    = halted_q;
        overflow  = overflow_q;
    end

    // -------------------------------------------------------------------------
    // Buffer storage. It is never cleared; arm and reset empty the buffer by
    // clearing the pointers and the count.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && write) begin
            mem[wr_ptr] <= entry;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count, fetch counter and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            // HALT_STATE here means that a core which comes out of reset
            // already in FETCH still produces a clean first fetch event.
            state_d    <= HALT_STATE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            fetch_cnt  <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_d <= state;
            if (arm) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                cnt_q      <= '0;
                fetch_cnt  <= '0;
                halted_q   <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (write) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                // An overwrite pushes the oldest entry out, so the read
                // pointer moves with it.
                if (pop || overwrite) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                if (write && !pop && !full) begin
                    cnt_q <= cnt_q + (DEPTH_LOG2 + 1)'(1);
                end else if (pop && !write) begin
                    cnt_q <= cnt_q - (DEPTH_LOG2 + 1)'(1);
                end
                if (accept && !fetch_sat) begin
                    fetch_cnt <= fetch_cnt + CNT_W'(1);
                end
                if (overwrite || drop) begin
                    overflow_q <= 1'b1;
                end
                if ((fsm_q == S_CAPTURE) && (state == HALT_STATE)) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

`ifdef PDP8_TRACE_LIMIT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stop_q <= 1'b0;
        end else if (arm) begin
            stop_q <= 1'b0;
        end else if (limit_hit) begin
            stop_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pdp8_trace_buffer
//
// Directed bench for pdp8_trace_buffer. The bench has three instances, and
// every instance receives the same core-side stimulus:
//   dut    : default parameters (depth 64, wrap mode on)
//   dut_w1 : depth 4, wrap mode on, 3-bit fetch counter (to test saturation)
//   dut_w0 : depth 4, wrap mode off
// Each instance has its own rd_ready input.
// -----------------------------------------------------------------------------
module tb_pdp8_trace_buffer;

    localparam logic [3:0] FETCH = 4'b0000;
    localparam logic [3:0] EXEC  = 4'b0001;
    localparam logic [3:0] HALT  = 4'b1100;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [14:0] pc;
    logic [11:0] mb;
    logic [11:0] ac;
    logic        l;
    logic        ion;
    logic        arm;
    logic        trig_en;
    logic [14:0] trig_pc;
    logic [31:0] limit;
    logic        rdy0, rdy1, rdy2;

    logic        rd_valid0, rd_valid1, rd_valid2;
    logic [40:0] rd_data0, rd_data1, rd_data2;
    logic [6:0]  count0;
    logic [2:0]  count1, count2;
    logic [31:0] fetches0, fetches2;
    logic [2:0]  fetches1;
    logic        cap0, cap1, cap2;
    logic        halt0, halt1, halt2;
    logic        ovf0, ovf1, ovf2;
    logic        stop0, stop1, stop2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdp8_trace_buffer dut (
        .clk(clk), .reset(reset), .state(state), .pc(pc), .mb(mb), .ac(ac),
        .l(l), .ion(ion), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
`ifdef PDP8_TRACE_LIMIT_EN
        .limit(limit), .stop_req(stop0),
`endif
        .rd_ready(rdy0), .rd_valid(rd_valid0), .rd_data(rd_data0),
        .count(count0), .fetches(fetches0), .capturing(cap0),
        .halted(halt0), .overflow(ovf0)
    );

    pdp8_trace_buffer #(.DEPTH_LOG2(2), .CNT_W(3), .WRAP_MODE(1'b1)) dut_w1 (
        .clk(clk), .reset(reset), .state(state), .pc(pc), .mb(mb), .ac(ac),
        .l(l), .ion(ion), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
`ifdef PDP8_TRACE_LIMIT_EN
        .limit(limit[2:0]), .stop_req(stop1),
`endif
        .rd_ready(rdy1), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .count(count1), .fetches(fetches1), .capturing(cap1),
        .halted(halt1), .overflow(ovf1)
    );

    pdp8_trace_buffer #(.DEPTH_LOG2(2), .WRAP_MODE(1'b0)) dut_w0 (
        .clk(clk), .reset(reset), .state(state), .pc(pc), .mb(mb), .ac(ac),
        .l(l), .ion(ion), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
`ifdef PDP8_TRACE_LIMIT_EN
        .limit(limit), .stop_req(stop2),
`endif
        .rd_ready(rdy2), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .count(count2), .fetches(fetches2), .capturing(cap2),
        .halted(halt2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete instruction: one FETCH cycle, then one EXEC cycle.
    task automatic fetch(input logic [14:0] p);
        state = FETCH;
        pc    = p;
        tick();
        state = EXEC;
        tick();
    endtask

    task automatic do_arm(input logic te, input logic [14:0] tp);
        arm     = 1'b1;
        trig_en = te;
        trig_pc = tp;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        logic [40:0] exp_entry;
        reset = 1'b0; state = EXEC; pc = '0; mb = '0; ac = '0; l = 1'b0;
        ion = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; limit = '0;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
        tick();
        tick();

        check("rst_count",    count0,    0);
        check("rst_valid",    rd_valid0, 0);
        check("rst_data",     rd_data0,  0);
        check("rst_fetches",  fetches0,  0);
        check("rst_capture",  cap0,      0);
        check("rst_halted",   halt0,     0);
        check("rst_overflow", ovf0,      0);

        reset = 1'b0;
        reset = 1'b1;
        tick();

        // Basic capture of three fetches, followed by ordered readout.
        do_arm(1'b0, '0);
        check("t1_capturing", cap0, 1);
        mb = 12'o7001; ac = 12'o1234; l = 1'b1; ion = 1'b1;
        fetch(15'o0200);
        mb = 12'o0000; ac = 12'o0000; l = 1'b0; ion = 1'b0;
        fetch(15'o0201);
        fetch(15'o0202);
        check("t1_count",   count0,   3);
        check("t1_fetches", fetches0, 3);
        exp_entry = {15'o0200, 12'o7001, 1'b1, 12'o1234, 1'b1};
        check("t1_entry0", rd_data0, exp_entry);
        rdy0 = 1'b1;
        check("t1_pop0", rd_data0[40:26], 15'o0200);
        tick();
        check("t1_pop1", rd_data0[40:26], 15'o0201);
        tick();
        check("t1_pop2", rd_data0[40:26], 15'o0202);
        tick();
        check("t1_empty", rd_valid0, 0);
        tick();
        check("t1_pop_empty_count", count0, 0);
        rdy0 = 1'b0;

        // A long FETCH state produces exactly one entry.
        state = FETCH; pc = 15'o0300;
        repeat (5) tick();
        state = EXEC;
        tick();
        check("t2_count",   count0,   1);
        check("t2_fetches", fetches0, 4);
        check("t2_pc",      rd_data0[40:26], 15'o0300);

        // PC trigger: capture starts with the fetch at trig_pc.
        do_arm(1'b1, 15'o0205);
        check("t3_wait_not_capturing", cap0, 0);
        check("t3_arm_cleared",        count0, 0);
        for (int i = 0; i < 8; i++) fetch(15'o0200 + 15'(i));
        check("t3_count",   count0,   3);
        check("t3_fetches", fetches0, 3);
        rdy0 = 1'b1;
        check("t3_pop0", rd_data0[40:26], 15'o0205);
        tick();
        check("t3_pop1", rd_data0[40:26], 15'o0206);
        tick();
        check("t3_pop2", rd_data0[40:26], 15'o0207);
        tick();
        rdy0 = 1'b0;

        // Full buffer: depth 4 with wrap on and with wrap off.
        do_arm(1'b0, '0);
        for (int i = 1; i <= 6; i++) fetch(15'(i));
        check("t4_w1_count",    count1, 4);
        check("t4_w1_overflow", ovf1,   1);
        check("t4_w1_capture",  cap1,   1);
        check("t4_w0_count",    count2, 4);
        check("t4_w0_overflow", ovf2,   1);
        check("t4_w0_frozen",   cap2,   0);
        check("t4_big_count",   count0, 6);
        check("t4_big_ovf",     ovf0,   0);
        rdy1 = 1'b1; rdy2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_w1_read", rd_data1[40:26], 15'(3 + i));
            check("t4_w0_read", rd_data2[40:26], 15'(1 + i));
            tick();
        end
        check("t4_w1_drained", rd_valid1, 0);
        rdy1 = 1'b0; rdy2 = 1'b0;
        check("t4_w1_fetches", fetches1, 6);
        fetch(15'd7);
        fetch(15'd8);
        check("t4_w1_saturate", fetches1, 7);

        // Full buffer with a push and a pop in the same cycle.
        do_arm(1'b0, '0);
        for (int i = 0; i < 4; i++) fetch(15'd10 + 15'(i));
        rdy1 = 1'b1; rdy2 = 1'b1;
        state = FETCH; pc = 15'd14;
        check("t4b_w1_head", rd_data1[40:26], 15'd10);
        tick();
        rdy1 = 1'b0; rdy2 = 1'b0;
        state = EXEC;
        check("t4b_w1_count",    count1, 4);
        check("t4b_w1_overflow", ovf1,   0);
        check("t4b_w0_overflow", ovf2,   0);
        check("t4b_w0_capture",  cap2,   1);
        tick();
        rdy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4b_w1_read", rd_data1[40:26], 15'd11 + 15'(i));
            tick();
        end
        rdy1 = 1'b0;

        // Halt freezes capture; a later fetch is ignored; arm clears halted.
        do_arm(1'b0, '0);
        fetch(15'o0400);
        fetch(15'o0401);
        state = HALT;
        tick();
        state = EXEC;
        check("t5_halted",  halt0, 1);
        check("t5_capture", cap0,  0);
        fetch(15'o0402);
        check("t5_count",   count0,   2);
        check("t5_fetches", fetches0, 2);
        do_arm(1'b0, '0);
        check("t5_halt_cleared", halt0,  0);
        check("t5_rearm_count",  count0, 0);
        check("t5_rearm_cap",    cap0,   1);

        // Arm in the same cycle as a fetch event: arm wins.
        state = FETCH; pc = 15'o0500; arm = 1'b1; trig_en = 1'b0;
        tick();
        arm = 1'b0; state = EXEC;
        tick();
        check("arm_vs_fetch_count", count0, 0);

        // Reset in the middle of a session.
        fetch(15'o0600);
        check("pre_reset_count", count0, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_reset_count",   count0,    0);
        check("mid_reset_valid",   rd_valid0, 0);
        check("mid_reset_capture", cap0,      0);
        check("mid_reset_fetches", fetches0,  0);
        tick();

`ifdef PDP8_TRACE_LIMIT_EN
        // Fetch limit: stop on the fetch that makes fetches equal to 10.
        limit = 32'd10;
        do_arm(1'b0, '0);
        for (int i = 0; i < 9; i++) fetch(15'o1000 + 15'(i));
        check("t6_stop_before", stop0, 0);
        check("t6_cap_before",  cap0,  1);
        fetch(15'o1011);
        check("t6_stop",    stop0,    1);
        check("t6_fetches", fetches0, 10);
        check("t6_frozen",  cap0,     0);
        check("t6_count",   count0,   10);
        fetch(15'o1012);
        check("t6_no_eleventh", count0, 10);
        limit = '0;
        do_arm(1'b0, '0);
        check("t6_arm_clears_stop", stop0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
